bp_io_req_arbiter: RTL and testbench

- Shares one I/O CCE request port among num_lce_p uncached-request sources (LCEs).
- Round-robin arbitration into a one-entry output register.
- Per-source outstanding-request credit limiting.
- Credit return is taken by snooping LCE commands (uc_data / uc_st_done) issued by the I/O CCE.
- Sits between the LCE request network endpoints and the I/O CCE.

---
 rtl/bp_me_pkg.sv | 15 +
 rtl/bp_io_rr_arb.sv | 42 ++++
 rtl/bp_io_req_arbiter.sv | 153 +++++++++++++++
 tb/tb_bp_io_req_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
// ============================================================================
// Module : bp_me_pkg
// Brief  : Shared memory-end constants for the I/O request arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bp_me_pkg;

    localparam int bp_io_arb_perf_width_gp = 32;
    localparam int lce_cce_req_width_lp    = 64;

endpackage

`default_nettype wire

// File: rtl/bp_io_rr_arb.sv
// ============================================================================
// Module : bp_io_rr_arb
// Brief  : Combinational round-robin picker starting at a supplied pointer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bp_io_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_elig,
    input  logic [IDX_W-1:0]   i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant_oh,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_v
);

    int w_j;

    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_grant_v   = 1'b0;
        w_j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_j = int'(i_ptr) + i;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            if (!o_grant_v && i_en && i_elig[w_j]) begin
                o_grant_v      = 1'b1;
                o_grant_idx    = IDX_W'(w_j);
                o_grant_oh[w_j] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bp_io_req_arbiter.sv
// ============================================================================
// Module : bp_io_req_arbiter
// Brief  : Round-robin, credit-limited sharing of one I/O CCE request port.
//          Optional perf counters enabled by `define BP_IO_REQ_ARB_PERF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bp_io_req_arbiter
    import bp_me_pkg::*;
#(
    parameter int num_lce_p         = 4,
    parameter int lce_id_width_p    = 4,
    parameter int req_width_p       = lce_cce_req_width_lp,
    parameter int max_outstanding_p = 2
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [num_lce_p*req_width_p-1:0]     lce_req_i,
    input  logic [num_lce_p-1:0]                 lce_req_v_i,
    output logic [num_lce_p-1:0]                 lce_req_yumi_o,
    output logic [req_width_p-1:0]               io_req_o,
    output logic                                 io_req_v_o,
    input  logic                                 io_req_yumi_i,
    input  logic                                 lce_cmd_fire_i,
    input  logic [lce_id_width_p-1:0]            lce_cmd_dst_i,
    output logic                                 busy_o,
    output logic                                 err_o,
    output logic [bp_io_arb_perf_width_gp-1:0]   grant_cnt_o,
    output logic [bp_io_arb_perf_width_gp-1:0]   stall_cnt_o
);

    localparam int              IDX_W     = $clog2(num_lce_p);
    localparam int              CNT_W     = $clog2(max_outstanding_p + 1);
    localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(max_outstanding_p);

    logic [CNT_W-1:0]       r_cnt [num_lce_p];
    logic [IDX_W-1:0]       r_ptr;
    logic [req_width_p-1:0] r_req;
    logic                   r_v;
    logic                   r_err;

    logic [num_lce_p-1:0]   w_elig;
    logic [num_lce_p-1:0]   w_ret_oh;
    logic [num_lce_p-1:0]   w_cnt_nz;
    logic [num_lce_p-1:0]   w_grant_oh;
    logic [IDX_W-1:0]       w_grant_idx;
    logic                   w_grant_v;
    logic                   w_grant_en;
    logic                   w_dst_ok;
    logic                   w_err_set;

    always_comb begin
        w_elig   = '0;
        w_ret_oh = '0;
        w_cnt_nz = '0;
        for (int k = 0; k < num_lce_p; k++) begin
            w_cnt_nz[k] = (r_cnt[k] != '0);
            w_elig[k]   = lce_req_v_i[k] && (r_cnt[k] < C_MAX_CNT);
            w_ret_oh[k] = lce_cmd_fire_i && (int'(lce_cmd_dst_i) == k);
        end
    end

    assign w_dst_ok = (int'(lce_cmd_dst_i) < num_lce_p);

    // Gating with reset keeps consume strobes quiet while the flops are held.
    assign w_grant_en = reset_n_i && (!r_v || io_req_yumi_i);

    assign w_err_set = (|(w_ret_oh & ~w_cnt_nz))
                     | (lce_cmd_fire_i && !w_dst_ok)
                     | (io_req_yumi_i && !r_v);

    bp_io_rr_arb #(
        .NUM_REQ (num_lce_p),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .i_elig      (w_elig),
        .i_ptr       (r_ptr),
        .i_en        (w_grant_en),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx),
        .o_grant_v   (w_grant_v)
    );

    generate
        for (genvar k = 0; k < num_lce_p; k++) begin : g_cnt
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    r_cnt[k] <= '0;
                end else if (w_grant_oh[k] && !w_ret_oh[k]) begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end else if (!w_grant_oh[k] && w_ret_oh[k] && w_cnt_nz[k]) begin
                    r_cnt[k] <= r_cnt[k] - CNT_W'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_v   <= 1'b0;
            r_req <= '0;
            r_ptr <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_grant_v) begin
                r_v   <= 1'b1;
                r_req <= lce_req_i[int'(w_grant_idx)*req_width_p +: req_width_p];
                r_ptr <= (w_grant_idx == IDX_W'(num_lce_p - 1)) ? '0
                                                                : w_grant_idx + IDX_W'(1);
            end else if (io_req_yumi_i) begin
                r_v <= 1'b0;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign lce_req_yumi_o = w_grant_oh;
    assign io_req_o       = r_req;
    assign io_req_v_o     = r_v;
    assign err_o          = r_err;
    assign busy_o         = r_v || (|w_cnt_nz);

`ifdef BP_IO_REQ_ARB_PERF_EN
    logic [bp_io_arb_perf_width_gp-1:0] r_grant_cnt;
    logic [bp_io_arb_perf_width_gp-1:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_grant_v) begin
                r_grant_cnt <= r_grant_cnt + 1'b1;
            end
            if ((|lce_req_v_i) && !w_grant_v) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign grant_cnt_o = r_grant_cnt;
    assign stall_cnt_o = r_stall_cnt;
`else
    assign grant_cnt_o = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_io_req_arbiter.sv
// ============================================================================
// Module : tb_bp_io_req_arbiter
// Brief  : Directed table-driven bench for bp_io_req_arbiter (4 LCEs, 2 credits).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bp_io_req_arbiter;

    localparam int N  = 4;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N*RW-1:0] lce_req;
    logic [N-1:0]  lce_req_v = '0;
    logic [N-1:0]  lce_req_yumi;
    logic [RW-1:0] io_req;
    logic          io_req_v;
    logic          io_req_yumi = 1'b0;
    logic          cmd_fire = 1'b0;
    logic [3:0]    cmd_dst = '0;
    logic          busy;
    logic          err;
    logic [31:0]   grant_cnt;
    logic [31:0]   stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bp_io_req_arbiter #(
        .num_lce_p         (N),
        .lce_id_width_p    (4),
        .req_width_p       (RW),
        .max_outstanding_p (2)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .lce_req_i      (lce_req),
        .lce_req_v_i    (lce_req_v),
        .lce_req_yumi_o (lce_req_yumi),
        .io_req_o       (io_req),
        .io_req_v_o     (io_req_v),
        .io_req_yumi_i  (io_req_yumi),
        .lce_cmd_fire_i (cmd_fire),
        .lce_cmd_dst_i  (cmd_dst),
        .busy_o         (busy),
        .err_o          (err),
        .grant_cnt_o    (grant_cnt),
        .stall_cnt_o    (stall_cnt)
    );

    typedef struct {
        logic [3:0]  v;
        logic        yumi;
        logic        fire;
        logic [3:0]  dst;
        logic [3:0]  exp_gnt;
        logic        exp_v;
        logic [15:0] exp_req;
        logic        exp_err;
        logic        exp_busy;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(logic [3:0] v, logic yumi, logic fire, logic [3:0] dst,
                                logic [3:0] gnt, logic ev, logic [15:0] rq,
                                logic er, logic bz);
        vec_t t;
        t.v = v; t.yumi = yumi; t.fire = fire; t.dst = dst;
        t.exp_gnt = gnt; t.exp_v = ev; t.exp_req = rq; t.exp_err = er; t.exp_busy = bz;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic yumi, input logic fire,
                         input logic [3:0] dst);
        lce_req_v   = v;
        io_req_yumi = yumi;
        cmd_fire    = fire;
        cmd_dst     = dst;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            lce_req[k*RW +: RW] = 16'hA0A0 + 16'(k);
        end

        //            v      yumi  fire  dst   gnt    v     req       err   busy
        tbl[0]  = mk(4'hF, 1'b0, 1'b0, 4'd0, 4'h1, 1'b1, 16'hA0A0, 1'b0, 1'b1);
        tbl[1]  = mk(4'hF, 1'b1, 1'b0, 4'd0, 4'h2, 1'b1, 16'hA0A1, 1'b0, 1'b1);
        tbl[2]  = mk(4'hF, 1'b1, 1'b0, 4'd0, 4'h4, 1'b1, 16'hA0A2, 1'b0, 1'b1);
        tbl[3]  = mk(4'hF, 1'b1, 1'b0, 4'd0, 4'h8, 1'b1, 16'hA0A3, 1'b0, 1'b1);
        tbl[4]  = mk(4'hF, 1'b1, 1'b0, 4'd0, 4'h1, 1'b1, 16'hA0A0, 1'b0, 1'b1);
        tbl[5]  = mk(4'h0, 1'b1, 1'b1, 4'd0, 4'h0, 1'b0, 16'hA0A0, 1'b0, 1'b1);
        tbl[6]  = mk(4'h0, 1'b0, 1'b1, 4'd0, 4'h0, 1'b0, 16'hA0A0, 1'b0, 1'b1);
        tbl[7]  = mk(4'h0, 1'b0, 1'b1, 4'd1, 4'h0, 1'b0, 16'hA0A0, 1'b0, 1'b1);
        tbl[8]  = mk(4'h0, 1'b0, 1'b1, 4'd2, 4'h0, 1'b0, 16'hA0A0, 1'b0, 1'b1);
        tbl[9]  = mk(4'h0, 1'b0, 1'b1, 4'd3, 4'h0, 1'b0, 16'hA0A0, 1'b0, 1'b0);
        tbl[10] = mk(4'h4, 1'b0, 1'b0, 4'd0, 4'h4, 1'b1, 16'hA0A2, 1'b0, 1'b1);
        tbl[11] = mk(4'h4, 1'b1, 1'b0, 4'd0, 4'h4, 1'b1, 16'hA0A2, 1'b0, 1'b1);
        tbl[12] = mk(4'h4, 1'b1, 1'b0, 4'd0, 4'h0, 1'b0, 16'hA0A2, 1'b0, 1'b1);
        tbl[13] = mk(4'h4, 1'b0, 1'b0, 4'd0, 4'h0, 1'b0, 16'hA0A2, 1'b0, 1'b1);
        tbl[14] = mk(4'h4, 1'b0, 1'b1, 4'd2, 4'h0, 1'b0, 16'hA0A2, 1'b0, 1'b1);
        tbl[15] = mk(4'h4, 1'b0, 1'b0, 4'd0, 4'h4, 1'b1, 16'hA0A2, 1'b0, 1'b1);
        tbl[16] = mk(4'h2, 1'b0, 1'b0, 4'd0, 4'h0, 1'b1, 16'hA0A2, 1'b0, 1'b1);
        tbl[17] = mk(4'h2, 1'b0, 1'b0, 4'd0, 4'h0, 1'b1, 16'hA0A2, 1'b0, 1'b1);
        tbl[18] = mk(4'h2, 1'b1, 1'b0, 4'd0, 4'h2, 1'b1, 16'hA0A1, 1'b0, 1'b1);
        tbl[19] = mk(4'h1, 1'b1, 1'b0, 4'd0, 4'h1, 1'b1, 16'hA0A0, 1'b0, 1'b1);
        tbl[20] = mk(4'h1, 1'b1, 1'b1, 4'd0, 4'h1, 1'b1, 16'hA0A0, 1'b0, 1'b1);
        tbl[21] = mk(4'h1, 1'b1, 1'b0, 4'd0, 4'h1, 1'b1, 16'hA0A0, 1'b0, 1'b1);
        tbl[22] = mk(4'h1, 1'b1, 1'b0, 4'd0, 4'h0, 1'b0, 16'hA0A0, 1'b0, 1'b1);
        tbl[23] = mk(4'h0, 1'b0, 1'b1, 4'd3, 4'h0, 1'b0, 16'hA0A0, 1'b1, 1'b1);
        tbl[24] = mk(4'h0, 1'b0, 1'b0, 4'd0, 4'h0, 1'b0, 16'hA0A0, 1'b1, 1'b1);
        tbl[25] = mk(4'h2, 1'b0, 1'b0, 4'd0, 4'h2, 1'b1, 16'hA0A1, 1'b1, 1'b1);

        // Reset state, with requests already pending.
        drive(4'hF, 1'b0, 1'b0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_yumi", 32'(lce_req_yumi), 32'h0);
        chk("rst_v", 32'(io_req_v), 32'h0);
        chk("rst_req", 32'(io_req), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_gcnt", grant_cnt, 32'h0);
        chk("rst_scnt", stall_cnt, 32'h0);
        @(negedge clk);
        drive(4'h0, 1'b0, 1'b0, 4'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].yumi, tbl[i].fire, tbl[i].dst);
            #1;
            chk($sformatf("v%0d_gnt", i), 32'(lce_req_yumi), 32'(tbl[i].exp_gnt));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_iov", i), 32'(io_req_v), 32'(tbl[i].exp_v));
            chk($sformatf("v%0d_req", i), 32'(io_req), 32'(tbl[i].exp_req));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
        end

        // Asynchronous reset mid-stream: register full, credits outstanding.
        @(negedge clk);
        drive(4'hF, 1'b0, 1'b0, 4'd0);
        reset_n = 1'b0;
        #1;
        chk("arst_v", 32'(io_req_v), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_err", 32'(err), 32'h0);
        chk("arst_yumi", 32'(lce_req_yumi), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_gnt", 32'(lce_req_yumi), 32'h1);
        @(posedge clk);
        #1;
        chk("post_rst_req", 32'(io_req), 32'hA0A0);

        // Out-of-range return: flags error, leaves credit state alone.
        @(negedge clk);
        drive(4'h0, 1'b1, 1'b1, 4'd7);
        @(posedge clk);
        #1;
        chk("dst7_err", 32'(err), 32'h1);
        chk("dst7_v", 32'(io_req_v), 32'h0);
        @(negedge clk);
        drive(4'h1, 1'b0, 1'b0, 4'd0);
        #1;
        chk("dst7_cnt1_gnt", 32'(lce_req_yumi), 32'h1);
        @(negedge clk);
        drive(4'h1, 1'b1, 1'b0, 4'd0);
        #1;
        chk("dst7_cnt2_gnt", 32'(lce_req_yumi), 32'h0);

        // Consume strobe while empty.
        @(negedge clk);
        drive(4'h0, 1'b0, 1'b0, 4'd0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        drive(4'h0, 1'b1, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        chk("yumi_empty_err", 32'(err), 32'h1);

        // Perf: 10 grants, then 3 cycles blocked behind a full register.
        @(negedge clk);
        drive(4'h0, 1'b0, 1'b0, 4'd0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        drive(4'h1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(4'h1, 1'b1, 1'b1, 4'd0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(4'h1, 1'b0, 1'b0, 4'd0);
        end
        @(negedge clk);
        drive(4'h0, 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        chk("perf_err", 32'(err), 32'h0);
        chk("perf_v", 32'(io_req_v), 32'h1);
`ifdef BP_IO_REQ_ARB_PERF_EN
        chk("perf_grants", grant_cnt, 32'd10);
        chk("perf_stalls", stall_cnt, 32'd3);
`else
        chk("perf_grants", grant_cnt, 32'd0);
        chk("perf_stalls", stall_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
